// File: rtl/gps_gate_controller_pkg.sv
// Shared definitions for the GPS gate controller: default widths and FSM state encodings.
`default_nettype none

package gps_gate_controller_pkg;

    localparam int COUNTERWIDTH_DEF  = 32;
    localparam int GPSCLOCKWIDTH_DEF = 5;
    localparam int TIMEOUTWIDTH_DEF  = 27;
    localparam int PPS_TIMEOUT_DEF   = 110_000_000;

    // One-hot encoding keeps the state decode to a single bit per state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_GATING = 2'b10
    } gate_state_e;

endpackage : gps_gate_controller_pkg

`default_nettype wire

// File: rtl/gps_gate_controller_pps_edge_detector.sv
// Synchronises the raw GPS pulse and flags its rising edge, plus a one-cycle-early look-ahead.
`default_nettype none

module pps_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic edge_o,
    output logic edge_next_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_o      = sync2_q & ~hist_q;
    // Equals the value edge_o will take on the next cycle.
    assign edge_next_o = sync1_q & ~sync2_q;

endmodule : pps_edge_detector

`default_nettype wire

// File: rtl/gps_gate_controller.sv
// Gates the external reference-clock counter between GPS PPS edges, latches averaged counts,
// hands them to the SPI side via valid/ack and watches for loss of the PPS signal.
`default_nettype none

module gps_gate_controller
    import gps_gate_controller_pkg::*;
#(
    parameter int COUNTERWIDTH  = COUNTERWIDTH_DEF,
    parameter int GPSCLOCKWIDTH = GPSCLOCKWIDTH_DEF,
    parameter int TIMEOUTWIDTH  = TIMEOUTWIDTH_DEF,
    parameter int PPS_TIMEOUT   = PPS_TIMEOUT_DEF
) (
    input  logic                     system_clk,
    input  logic                     rst_n,
    input  logic                     gps_pulse,
    input  logic [GPSCLOCKWIDTH-1:0] cfg_average,
    input  logic                     cfg_valid,
    input  logic                     result_ack,
    input  logic [COUNTERWIDTH-1:0]  count_value,
    output logic                     count_clear,
    output logic                     count_enable,
    output logic [COUNTERWIDTH-1:0]  result,
    output logic                     result_valid,
    output logic                     result_overrun,
    output logic                     pps_lost,
    output logic                     irq
);

    localparam logic [TIMEOUTWIDTH-1:0] TIMEOUT_LAST = TIMEOUTWIDTH'(PPS_TIMEOUT - 1);

    gate_state_e state_q, state_d;

    logic [GPSCLOCKWIDTH-1:0] cfg_pending_q, cfg_pending_d;
    logic [GPSCLOCKWIDTH-1:0] cfg_active_q,  cfg_active_d;
    logic [GPSCLOCKWIDTH-1:0] intervals_q,   intervals_d;
    logic [TIMEOUTWIDTH-1:0]  timer_q,       timer_d;
    logic [COUNTERWIDTH-1:0]  result_q,      result_d;
    logic                     valid_q,       valid_d;
    logic                     overrun_q,     overrun_d;
    logic                     lost_q,        lost_d;
    logic                     clear_q,       clear_d;
    logic                     enable_q,      enable_d;
    logic                     irq_q,         irq_d;

    logic                     pps_edge;
    logic                     pps_edge_next;
    logic                     latch;
    logic [COUNTERWIDTH:0]    count_sum;
    logic [COUNTERWIDTH-1:0]  count_sat;

    pps_edge_detector u_pps_edge (
        .clk         (system_clk),
        .rst_n       (rst_n),
        .pulse_i     (gps_pulse),
        .edge_o      (pps_edge),
        .edge_next_o (pps_edge_next)
    );

    // The latching cycle itself is one more reference cycle than the counter has seen.
    assign count_sum = {1'b0, count_value} + {{COUNTERWIDTH{1'b0}}, 1'b1};
    assign count_sat = count_sum[COUNTERWIDTH] ? {COUNTERWIDTH{1'b1}} : count_sum[COUNTERWIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        cfg_pending_d = cfg_valid ? cfg_average : cfg_pending_q;
        cfg_active_d  = cfg_active_q;
        intervals_d   = intervals_q;
        result_d      = result_q;
        valid_d       = valid_q;
        overrun_d     = overrun_q;
        lost_d        = lost_q;
        latch         = 1'b0;

        if (state_q == ST_IDLE || pps_edge) begin
            timer_d = '0;
        end else if (timer_q != {TIMEOUTWIDTH{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        if (result_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pps_edge) begin
                    state_d      = ST_GATING;
                    cfg_active_d = cfg_pending_q;
                    intervals_d  = '0;
                    lost_d       = 1'b0;
                end
            end
            ST_GATING: begin
                if (pps_edge) begin
                    if (intervals_q == cfg_active_q) begin
                        latch = 1'b1;
                    end else begin
                        intervals_d = intervals_q + 1'b1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pending config is sampled before this cycle's cfg_valid, so a same-cycle update waits a gate.
        if (latch) begin
            result_d     = count_sat;
            cfg_active_d = cfg_pending_q;
            intervals_d  = '0;
            valid_d      = 1'b1;
            if (result_ack) begin
                overrun_d = overrun_q;
            end else if (valid_q) begin
                overrun_d = 1'b1;
            end
        end

        // Clear is issued from the look-ahead so it lands in the edge cycle, making the count exact.
        clear_d  = pps_edge_next && (state_d == ST_IDLE || intervals_d == cfg_active_d);
        enable_d = (state_d == ST_GATING);
        irq_d    = valid_d | lost_d;
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_pending_q <= '0;
            cfg_active_q  <= '0;
            intervals_q   <= '0;
            timer_q       <= '0;
            result_q      <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            lost_q        <= 1'b0;
            clear_q       <= 1'b0;
            enable_q      <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_active_q  <= cfg_active_d;
            intervals_q   <= intervals_d;
            timer_q       <= timer_d;
            result_q      <= result_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            lost_q        <= lost_d;
            clear_q       <= clear_d;
            enable_q      <= enable_d;
            irq_q         <= irq_d;
        end
    end

    assign count_clear    = clear_q;
    assign count_enable   = enable_q;
    assign result         = result_q;
    assign result_valid   = valid_q;
    assign result_overrun = overrun_q;
    assign pps_lost       = lost_q;
    assign irq            = irq_q;

endmodule : gps_gate_controller

`default_nettype wire
